// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
// M-stage load/store unit of the pipelined MIPS core and initiator of the
// external data-memory interface.
//   * Turns M-stage load/store ops into a word-aligned address, lane-replicated
//     store data and byte enables.
//   * Flags misaligned or out-of-range accesses (m_exc_adel / m_exc_ades).
//   * Registers the returned read word into the M->W pipeline register.
//   * Extracts and sign/zero-extends the load result in W and drives the GRF
//     write-back ports.
//   * Keeps retired-load and issued-store counters.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   m_valid, m_stall     M-stage valid / hold
//   m_op                 0 NONE,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//   m_addr               effective byte address
//   m_store_data         rt value for stores
//   m_rd, m_pc           load destination register, instruction PC
//   m_data_addr          word-aligned byte address to memory
//   m_data_wdata         lane-replicated store data
//   m_data_byteen        byte write enables
//   m_inst_addr          PC of the issuing instruction
//   m_data_rdata         read word, combinational from m_data_addr
//   m_exc_adel/_ades     load / store address error
//   w_grf_we/_addr/_wdata  load write-back
//   w_inst_addr          PC of the load in W
//   load_cnt, store_cnt  retired loads / issued stores (wrapping)
// -----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int DM_WORDS = 4096,
    parameter int OP_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m_valid,
    input  logic            m_stall,
    input  logic [OP_W-1:0] m_op,
    input  logic [31:0]     m_addr,
    input  logic [31:0]     m_store_data,
    input  logic [4:0]      m_rd,
    input  logic [31:0]     m_pc,
    output logic [31:0]     m_data_addr,
    output logic [31:0]     m_data_wdata,
    output logic [3:0]      m_data_byteen,
    output logic [31:0]     m_inst_addr,
    input  logic [31:0]     m_data_rdata,
    output logic            m_exc_adel,
    output logic            m_exc_ades,
    output logic            w_grf_we,
    output logic [4:0]      w_grf_addr,
    output logic [31:0]     w_grf_wdata,
    output logic [31:0]     w_inst_addr,
    output logic [31:0]     load_cnt,
    output logic [31:0]     store_cnt
);

    localparam logic [OP_W-1:0] OP_NONE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LHU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LBU  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SH   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SB   = OP_W'(8);

    // First byte address past the end of data memory.
    localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

    // Select and extend the load result from the registered read word.
    function automatic logic [31:0] extract_load(
        input logic [OP_W-1:0] op,
        input logic [1:0]      lo,
        input logic [31:0]     word
    );
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (lo)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = 8'h00;
        endcase
        case (op)
            OP_LW:   res_v = word;
            OP_LH:   res_v = {{16{half_v[15]}}, half_v};
            OP_LHU:  res_v = {16'h0000, half_v};
            OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  res_v = {24'h000000, byte_v};
            default: res_v = 32'h0000_0000;
        endcase
        return res_v;
    endfunction

    logic w_is_load;
    logic w_is_store;
    logic w_misalign;
    logic w_fault;
    logic w_issue;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    logic            r_valid_w;
    logic [OP_W-1:0] r_op;
    logic [1:0]      r_lo;
    logic [4:0]      r_rd;
    logic [31:0]     r_pc;
    logic [31:0]     r_rdata;
    logic [31:0]     r_load_cnt;
    logic [31:0]     r_store_cnt;

    // Op decode: load/store class and the alignment rule each op imposes.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        case (m_op)
            OP_LW:  begin w_is_load  = 1'b1; w_misalign = (m_addr[1:0] != 2'b00); end
            OP_LH:  begin w_is_load  = 1'b1; w_misalign = m_addr[0]; end
            OP_LHU: begin w_is_load  = 1'b1; w_misalign = m_addr[0]; end
            OP_LB:  begin w_is_load  = 1'b1; w_misalign = 1'b0; end
            OP_LBU: begin w_is_load  = 1'b1; w_misalign = 1'b0; end
            OP_SW:  begin w_is_store = 1'b1; w_misalign = (m_addr[1:0] != 2'b00); end
            OP_SH:  begin w_is_store = 1'b1; w_misalign = m_addr[0]; end
            OP_SB:  begin w_is_store = 1'b1; w_misalign = 1'b0; end
            OP_NONE: begin w_is_load = 1'b0; w_is_store = 1'b0; w_misalign = 1'b0; end
            default: begin w_is_load = 1'b0; w_is_store = 1'b0; w_misalign = 1'b0; end
        endcase
    end

    // A fault is only meaningful for memory ops; NONE never faults.
    assign w_fault = (w_is_load | w_is_store) & (w_misalign | (m_addr >= ADDR_LIMIT));
    assign w_issue = m_valid & ~m_stall & ~reset & ~w_fault;

    // Store lane steering; enables only for a store that actually issues.
    always_comb begin
        w_byteen = 4'b0000;
        w_wdata  = m_store_data;
        case (m_op)
            OP_SW: begin
                w_wdata  = m_store_data;
                w_byteen = 4'b1111;
            end
            OP_SH: begin
                w_wdata  = {2{m_store_data[15:0]}};
                w_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                w_wdata  = {4{m_store_data[7:0]}};
                w_byteen = 4'b0001 << m_addr[1:0];
            end
            default: begin
                w_wdata  = m_store_data;
                w_byteen = 4'b0000;
            end
        endcase
        if (!w_issue) begin
            w_byteen = 4'b0000;
        end else begin
            w_byteen = w_byteen;
        end
    end

    // M->W pipeline register; a non-issuing load leaves a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_w <= 1'b0;
            r_op      <= OP_NONE;
            r_lo      <= 2'b00;
            r_rd      <= 5'd0;
            r_pc      <= 32'h0000_0000;
            r_rdata   <= 32'h0000_0000;
        end else begin
            r_valid_w <= w_issue & w_is_load;
            r_op      <= m_op;
            r_lo      <= m_addr[1:0];
            r_rd      <= m_rd;
            r_pc      <= m_pc;
            r_rdata   <= m_data_rdata;
        end
    end

    // Retired-access counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_cnt  <= 32'd0;
            r_store_cnt <= 32'd0;
        end else begin
            if (w_issue && w_is_load) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
            if (w_issue && w_is_store) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
        end
    end

    assign m_data_addr   = {m_addr[31:2], 2'b00};
    assign m_data_wdata  = w_wdata;
    assign m_data_byteen = w_byteen;
    assign m_inst_addr   = m_pc;
    assign m_exc_adel    = m_valid & w_is_load & w_fault;
    assign m_exc_ades    = m_valid & w_is_store & w_fault;

    // Write-back is also masked while reset is asserted, before the register clears.
    assign w_grf_we    = r_valid_w & (r_rd != 5'd0) & ~reset;
    assign w_grf_addr  = r_rd;
    assign w_grf_wdata = extract_load(r_op, r_lo, r_rdata);
    assign w_inst_addr = r_pc;
    assign load_cnt    = r_load_cnt;
    assign store_cnt   = r_store_cnt;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- CPU-side initiator of the data-memory interface: the M-stage load/store unit of the pipelined MIPS core.
- Converts M-stage load/store ops into word-aligned address, lane-replicated write data and byte enables for the external data memory.
- Registers the returned read word into an M->W pipeline register; extracts and sign/zero-extends load results in W.
- Drives the GRF write-back trace ports for loads, flags misaligned or out-of-range accesses, and keeps retired-access counters.

Parameters:
DM_WORDS, 4096, data memory depth in words; legal byte address range is 0 .. 4*DM_WORDS-1
OP_W, 4, width of the op code field

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m_valid  input  1  M-stage instruction valid
m_stall  input  1  M stage held this cycle
m_op  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; other codes treated as NONE
m_addr  input  32  effective byte address
m_store_data  input  32  rt value for stores
m_rd  input  5  load destination register
m_pc  input  32  M-stage instruction PC
m_data_addr  output  32  byte address to memory, {m_addr[31:2],2'b00}
m_data_wdata  output  32  lane-replicated store data
m_data_byteen  output  4  byte write enables
m_inst_addr  output  32  PC of the issuing store, equal to m_pc
m_data_rdata  input  32  read word, combinational from m_data_addr
m_exc_adel  output  1  load address error, combinational
m_exc_ades  output  1  store address error, combinational
w_grf_we  output  1  load write-back enable
w_grf_addr  output  5  load write-back register
w_grf_wdata  output  32  extended load data
w_inst_addr  output  32  PC of the load in W
load_cnt  output  32  retired loads
store_cnt  output  32  issued stores

Behaviour:
- Issue: issue = m_valid & ~m_stall & ~reset & no exception.
- Misalignment:
  - LW/SW fault when addr[1:0]!=0.
  - LH/LHU/SH fault when addr[0]!=0.
  - Bytes are never misaligned.
- Range: access faults when m_addr >= 4*DM_WORDS.
- Exception flags: m_exc_adel / m_exc_ades assert when m_valid & fault, for loads / stores respectively. They are independent of m_stall.
- Store lanes:
  - SW: byteen=1111, wdata=data.
  - SH: byteen=0011 if addr[1]=0, else 1100; wdata={2{data[15:0]}}.
  - SB: byteen=0001<<addr[1:0]; wdata={4{data[7:0]}}.
- Byte enables are 0000 whenever the access is not an issuing store: NONE, loads, faulted, stalled, invalid, or reset.
- M->W register on every posedge. It captures valid_w = issue & is_load, plus op, addr[1:0], rd, pc and m_data_rdata.
- W extraction (combinational from the register):
  - LW: the full word.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LB/LBU: byte selected by addr[1:0], sign- or zero-extended.
- w_grf_we = valid_w & (rd != 0). A faulted or stalled load produces a W bubble.
- Load latency: rdata sampled at the M-cycle edge; result visible in W the following cycle.
- Counters:
  - store_cnt increments on each issuing store; load_cnt increments when valid_w is registered.
  - Both are 32-bit and wrap from FFFFFFFF to 0.
- Reset:
  - Takes effect at the next posedge, including mid-stream.
  - Clears the W register (valid_w=0, pc=0, data=0) and both counters.
  - While reset is high, byteen=0000 and w_grf_we=0.
  - Other outputs follow their combinational inputs.
- Simultaneous events: a stall with an exception reports the exception flag but issues nothing. A load to $0 is counted but not written back.

Test Plan:
- SW data=0x12345678 addr=0x0000_0010 -> m_data_addr=0x10, byteen=1111, wdata=0x12345678; store_cnt 0->1.
- SB data=0x000000AB addr=0x13 -> m_data_addr=0x10, byteen=1000, wdata=0xABABABAB. SH data=0xBEEF addr=0x22 -> byteen=1100, wdata=0xBEEFBEEF.
- Memory word 0x8081F2F3 at 0x20:
  - LB addr=0x21 -> W next cycle: wdata=0xFFFFFFF2, we=1, w_inst_addr=m_pc.
  - LBU addr=0x23 -> 0x00000080.
  - LH addr=0x22 -> 0xFFFF8081.
  - LHU addr=0x20 -> 0x0000F2F3.
- Faults and suppressed issue:
  - LW addr=0x06 -> m_exc_adel=1, W bubble.
  - SH addr=0x11 -> m_exc_ades=1, byteen=0000.
  - SW addr=0x4000 -> m_exc_ades=1, byteen=0000.
  - Stalled SW -> byteen=0000, store_cnt unchanged.
- Reset mid-stream: LW in flight, reset high for one cycle -> w_grf_we=0 the next cycle; load_cnt=0, store_cnt=0. LW to $0 -> load_cnt+1, w_grf_we=0.
